// File: rtl/sram_pkg.sv
// Shared widths, request record layout and bridge state encoding for the
// SRAM request bridge and its request queue.
package sram_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 4;
    localparam int REQ_W  = ADDR_W + DATA_W + 1;

    typedef enum logic [1:0] {
        BR_IDLE   = 2'd0,
        BR_ACCESS = 2'd1,
        BR_RESP   = 2'd2
    } bridge_state_e;

    // Queue entry layout: {rnw, addr, wdata}
    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_req_fifo.sv
// Synchronous request queue; push and pop in the same cycle are accepted at
// any non-empty occupancy, including full, leaving the occupancy unchanged.
module sram_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    assign pop_data = store[rd_ptr];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/sram_req_bridge.sv
// Host-to-SRAM request bridge: queues requests, issues one SRAM operation at
// a time, returns read data (or a timeout error) through a response port.
import sram_pkg::*;

module sram_req_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_enable,
    output logic              mem_rnw,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              err_sticky,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] S_IDLE   = BR_IDLE;
    localparam logic [1:0] S_ACCESS = BR_ACCESS;
    localparam logic [1:0] S_RESP   = BR_RESP;
    localparam int         CNT_W    = $clog2(TIMEOUT + 1);

    logic [1:0]        state;
    sram_req_t         head;
    sram_req_t         issue_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              sticky_q;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and req_ready is simply "queue not full".
    assign req_ready = !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty;

    sram_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid && req_ready),
        .push_data ({req_rnw, req_addr, req_wdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // cnt counts ACCESS cycles from 0, so the operation gets exactly TIMEOUT
    // cycles; mem_ready in the last one still completes normally.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            issue_q    <= '{rnw: 1'b1, addr: '0, wdata: '0};
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        issue_q <= head;
                        cnt     <= '0;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        if (issue_q.rnw) begin
                            rsp_data_q <= mem_rdata;
                            rsp_err_q  <= 1'b0;
                            state      <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (timeout_hit) begin
                        sticky_q <= 1'b1;
                        if (issue_q.rnw) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_enable = (state == S_ACCESS);
    assign mem_addr   = issue_q.addr;
    assign mem_wdata  = issue_q.wdata;
    assign mem_rnw    = issue_q.rnw;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_rdata  = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign err_sticky = sticky_q;
    assign busy       = !fifo_empty || (state != S_IDLE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_sram_req_bridge.sv
// Bench for sram_req_bridge: reactive SRAM model, in-order scoreboard for
// issued operations and read responses, vector table plus corner sequences.
module tb_sram_req_bridge;
    import sram_pkg::*;

    localparam int TIMEOUT = 15;
    localparam int NV      = 11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_addr;
    logic [3:0] req_wdata;
    logic       req_rnw;
    logic [9:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_enable;
    logic       mem_rnw;
    logic [3:0] mem_rdata;
    logic       mem_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic       rsp_err;
    logic       err_sticky;
    logic       busy;
    logic [1:0] fsm_state;

    sram_req_bridge #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rnw    (req_rnw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_enable (mem_enable),
        .mem_rnw    (mem_rnw),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .err_sticky (err_sticky),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exp_q [$];
    logic [14:0] iss_q [$];
    int          lat_q [$];
    logic [3:0]  sram    [1024];
    logic [3:0]  ref_mem [1024];
    logic        spur     = 1'b0;
    logic        rand_rsp = 1'b0;

    typedef struct {
        logic       rnw;
        logic [9:0] addr;
        logic [3:0] wdata;
        int         lat;
        logic [3:0] exp_rdata;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=no_event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic rnw, input logic [9:0] addr, input logic [3:0] wdata,
                        input int lat, input logic [3:0] exp_rd, input logic exp_err);
        int waited = 0;
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_addr  = addr;
        req_wdata = wdata;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 200) break;
            step();
        end
        if (waited > 200) begin
            fail("req_accept_timeout");
        end else begin
            iss_q.push_back({rnw, addr, wdata});
            lat_q.push_back(lat);
            if (rnw) exp_q.push_back({exp_err, exp_rd});
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(busy || exp_q.size() != 0 || iss_q.size() != 0), 0);
    endtask

    // Entered just after the acceptance cycle: one idle gap cycle, then ACCESS.
    task automatic count_enable(input string name, input int exp_en);
        int en = 0;
        @(negedge clk);
        chk({name, "_gap"}, 32'(mem_enable), 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mem_enable) break;
            en++;
        end
        chk({name, "_cycles"}, 32'(en), 32'(exp_en));
    endtask

    // SRAM model: completes each operation after its queued latency (-1 = never).
    initial begin : mem_model
        logic        in_op;
        int          acc_cnt;
        int          cur_lat;
        logic [14:0] cur_op;
        in_op   = 1'b0;
        acc_cnt = 0;
        cur_lat = -1;
        cur_op  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = 4'($urandom);
            if (!rst_n) begin
                in_op = 1'b0;
            end else if (mem_enable) begin
                if (!in_op) begin
                    in_op   = 1'b1;
                    acc_cnt = 0;
                    if (iss_q.size() == 0) begin
                        fail("issue_unexpected");
                        cur_op  = {mem_rnw, mem_addr, mem_wdata};
                        cur_lat = -1;
                    end else begin
                        cur_op  = iss_q.pop_front();
                        cur_lat = lat_q.pop_front();
                    end
                end
                chk("issue_op", 32'({mem_rnw, mem_addr, mem_wdata}), 32'(cur_op));
                if (cur_lat >= 0 && acc_cnt == cur_lat) begin
                    mem_ready = 1'b1;
                    if (mem_rnw) mem_rdata = sram[mem_addr];
                    else         sram[mem_addr] = mem_wdata;
                end
                acc_cnt++;
            end else begin
                in_op = 1'b0;
                if (spur) mem_ready = 1'b1;
            end
        end
    end

    initial begin : rsp_mon
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e[3:0]));
                    chk("rsp_err", 32'(rsp_err), 32'(e[4]));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        fail("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        logic [9:0] fa [6];
        logic       rnw;
        logic [9:0] addr;
        logic [3:0] wd;
        int         n;
        int         rsp_seen;
        int         en_seen;

        tbl[0]  = '{1'b0, 10'h3A7, 4'h9, 2,  4'h0};
        tbl[1]  = '{1'b1, 10'h3A7, 4'h0, 1,  4'h9};
        tbl[2]  = '{1'b0, 10'h015, 4'hC, 0,  4'h0};
        tbl[3]  = '{1'b1, 10'h015, 4'h0, 3,  4'hC};
        tbl[4]  = '{1'b1, 10'h3A7, 4'h0, 0,  4'h9};
        tbl[5]  = '{1'b0, 10'h3A7, 4'h2, 5,  4'h0};
        tbl[6]  = '{1'b1, 10'h3A7, 4'h0, 14, 4'h2};
        tbl[7]  = '{1'b1, 10'h200, 4'h0, 0,  4'h0};
        tbl[8]  = '{1'b0, 10'h3FF, 4'hF, 1,  4'h0};
        tbl[9]  = '{1'b1, 10'h3FF, 4'h0, 0,  4'hF};
        tbl[10] = '{1'b1, 10'h000, 4'h0, 2,  4'h0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_rnw   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_mem_enable", 32'(mem_enable), 0);
        chk("rst_mem_addr",   32'(mem_addr), 0);
        chk("rst_mem_wdata",  32'(mem_wdata), 0);
        chk("rst_mem_rnw",    32'(mem_rnw), 1);
        chk("rst_rsp_valid",  32'(rsp_valid), 0);
        chk("rst_rsp_rdata",  32'(rsp_rdata), 0);
        chk("rst_rsp_err",    32'(rsp_err), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_state",      32'(fsm_state), 32'(BR_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", 32'(req_ready), 1);

        // Single write, ready after 2 cycles: enable exactly 3 cycles, no response
        send(1'b0, 10'h3A7, 4'h9, 2, 4'h0, 1'b0);
        ref_mem[10'h3A7] = 4'h9;
        count_enable("wr", 3);
        chk("wr_rsp_valid", 32'(rsp_valid), 0);
        chk("wr_state_idle", 32'(fsm_state), 32'(BR_IDLE));
        chk("wr_hold_addr", 32'(mem_addr), 'h3A7);
        chk("wr_hold_wdata", 32'(mem_wdata), 'h9);
        chk("wr_hold_rnw", 32'(mem_rnw), 0);

        // Vector table, back to back
        step();
        for (int i = 0; i < NV; i++) begin
            send(tbl[i].rnw, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].exp_rdata, 1'b0);
            if (!tbl[i].rnw) ref_mem[tbl[i].addr] = tbl[i].wdata;
        end
        wait_idle("table_drain");
        chk("table_no_sticky", 32'(err_sticky), 0);

        // Random traffic with random response back-pressure
        rand_rsp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rnw  = 1'($urandom_range(0, 1));
            addr = 10'h3A0 + 10'($urandom_range(0, 7));
            wd   = 4'($urandom_range(0, 15));
            send(rnw, addr, wd, $urandom_range(0, 6), ref_mem[addr], 1'b0);
            if (!rnw) ref_mem[addr] = wd;
        end
        wait_idle("rand_drain");
        rand_rsp  = 1'b0;
        rsp_ready = 1'b1;

        // Fill the queue behind a stalled response, then push while it pops at full
        fa[0] = 10'h3A7; fa[1] = 10'h015; fa[2] = 10'h3FF;
        fa[3] = 10'h3A1; fa[4] = 10'h3A5; fa[5] = 10'h3A2;
        step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(1'b1, fa[k], 4'h0, 0, ref_mem[fa[k]], 1'b0);
        @(negedge clk);
        chk("full_req_ready", 32'(req_ready), 0);
        chk("full_rsp_valid", 32'(rsp_valid), 1);
        chk("full_busy", 32'(busy), 1);
        fork
            send(1'b1, fa[5], 4'h0, 0, ref_mem[fa[5]], 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_hold_ready", 32'(req_ready), 0);
                end
                step();
                rsp_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("pop_at_full_ready", 32'(req_ready), 0);
            end
        join
        wait_idle("full_drain");

        // Response held stable, spurious mem_ready ignored in RESP and IDLE
        rsp_ready = 1'b0;
        send(1'b1, 10'h015, 4'h0, 1, ref_mem[10'h015], 1'b0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        spur = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("resp_hold_valid", 32'(rsp_valid), 1);
            chk("resp_hold_rdata", 32'(rsp_rdata), 32'(ref_mem[10'h015]));
            chk("resp_hold_state", 32'(fsm_state), 32'(BR_RESP));
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("spur_idle_state", 32'(fsm_state), 32'(BR_IDLE));
            chk("spur_idle_enable", 32'(mem_enable), 0);
        end
        spur = 1'b0;
        step();

        // Read timeout: TIMEOUT enabled cycles, error response with zero data
        send(1'b1, 10'h0AB, 4'h0, -1, 4'h0, 1'b1);
        count_enable("rd_to", TIMEOUT);
        chk("rd_to_sticky", 32'(err_sticky), 1);
        wait_idle("rd_to_drain");

        // Write timeout: no response, sticky stays set
        send(1'b0, 10'h0AC, 4'h5, -1, 4'h0, 1'b0);
        count_enable("wr_to", TIMEOUT);
        chk("wr_to_rsp_valid", 32'(rsp_valid), 0);
        chk("wr_to_state", 32'(fsm_state), 32'(BR_IDLE));
        chk("wr_to_sticky", 32'(err_sticky), 1);

        // Reset mid-ACCESS with three queued requests
        step();
        for (int k = 0; k < 4; k++) send(1'b1, 10'h100 + 10'(k), 4'h0, -1, 4'h0, 1'b1);
        step();
        chk("mid_rst_pre_enable", 32'(mem_enable), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", 32'(mem_enable), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mid_rst_state", 32'(fsm_state), 32'(BR_IDLE));
        chk("mid_rst_sticky", 32'(err_sticky), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_rnw", 32'(mem_rnw), 1);
        exp_q.delete();
        iss_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        en_seen  = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            if (mem_enable) en_seen++;
        end
        chk("post_rst_rsp", 32'(rsp_seen), 0);
        chk("post_rst_issue", 32'(en_seen), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // Normal operation after reset
        step();
        send(1'b0, 10'h3A7, 4'h6, 1, 4'h0, 1'b0);
        send(1'b1, 10'h3A7, 4'h0, 0, 4'h6, 1'b0);
        wait_idle("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_bridge.md
SRAM_REQ_BRIDGE -- requirements
Module: sram_req_bridge

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-002 Parameter: TIMEOUT, default 15, max cycles from issue to mem_ready before abort.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  host request valid.
REQ-006 req_ready  output  1  bridge accepts request this cycle.
REQ-007 req_addr  input  10  word address; [9:4] row, [3:0] column word.
REQ-008 req_wdata  input  4  write data.
REQ-009 req_rnw  input  1  1=read, 0=write.
REQ-010 mem_addr  output  10  address to SRAM core.
REQ-011 mem_wdata  output  4  write data to SRAM core.
REQ-012 mem_enable  output  1  SRAM core chip select.
REQ-013 mem_rnw  output  1  SRAM core read_not_write.
REQ-014 mem_rdata  input  4  SRAM core data_out.
REQ-015 mem_ready  input  1  SRAM core operation-complete pulse.
REQ-016 rsp_valid  output  1  read response valid.
REQ-017 rsp_ready  input  1  host accepts response.
REQ-018 rsp_rdata  output  4  read data.
REQ-019 rsp_err  output  1  response is a timed-out read; rsp_rdata = 0.
REQ-020 err_sticky  output  1  any timeout since reset.
REQ-021 busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-022 Request accepted when req_valid && req_ready; req_ready = FIFO not full (no full-bypass).
REQ-023 Simultaneous push and pop SHALL be legal at any non-empty occupancy, including full; occupancy unchanged.
REQ-024 FSM states IDLE, ACCESS, RESP.
REQ-025 IDLE: FIFO non-empty -> pop head into issue register, go ACCESS next cycle; else stay.
REQ-026 ACCESS: mem_enable=1, mem_addr/mem_wdata/mem_rnw held constant from issue register for entire state.
REQ-027 ACCESS, mem_ready=1, write -> IDLE; no response generated.
REQ-028 ACCESS, mem_ready=1, read -> capture mem_rdata same cycle into response register, go RESP.
REQ-029 Cycle counter cleared on ACCESS entry; counter reaching TIMEOUT without mem_ready -> abort: mem_enable drops, err_sticky set; read -> RESP with rsp_err=1; write -> IDLE.
REQ-030 mem_ready and timeout in the same cycle: mem_ready wins, no error.
REQ-031 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; rsp_ready=1 -> IDLE; next issue no earlier than following cycle.
REQ-032 mem_ready outside ACCESS SHALL be ignored.
REQ-033 Requests issue strictly in acceptance order; one outstanding SRAM operation maximum.
REQ-034 mem_enable=0 in IDLE and RESP; mem_addr/mem_wdata/mem_rnw hold last issued values there.
REQ-035 Minimum request-to-response latency: accept cycle N, ACCESS entered N+2, response visible cycle after mem_ready.

Reset
REQ-036 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, req_ready=1 after release, mem_enable=0, mem_addr=0, mem_wdata=0, mem_rnw=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_sticky=0, busy=0, counter=0.
REQ-037 Reset mid-ACCESS or mid-RESP SHALL discard queued and in-flight operations with no response.

Structure
REQ-038 Shared package sram_pkg: ADDR_W=10, DATA_W=4, ROW_W=6, COL_W=4, bridge state enum.
REQ-039 One sub-module sram_req_fifo (synchronous FIFO, depth FIFO_DEPTH, width ADDR_W+DATA_W+1, full/empty flags).

Verification
REQ-040 Write 0x3A7 data 0x9, mem_ready after 2 cycles -> mem_enable high exactly until mem_ready, no rsp_valid.
REQ-041 Write 0x3A7=0x9 then read 0x3A7, memory model returns 0x9 -> rsp_valid with rsp_rdata=0x9, rsp_err=0.
REQ-042 Push 5 requests, rsp_ready=0, mem_ready immediate -> req_ready low at occupancy 4; reads complete in order once rsp_ready=1.
REQ-043 Read with mem_ready never asserted -> abort after 15 cycles, rsp_err=1, rsp_rdata=0, err_sticky=1 until reset.
REQ-044 Assert rst_n low mid-ACCESS with 3 queued -> mem_enable=0 immediately, busy=0, no response after release.
REQ-045 Push while popping at full FIFO -> req_ready stays 0, no loss or duplication, order preserved.
